rf_wb_arbiter: RTL and testbench

//  Write-port controller for the 2R1W register file (x0 hard-wired zero, sync write, comb read).

---
 rtl/rf_ctrl_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package rf_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int REG_X0     = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bit per architectural register for outstanding long-latency writes.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_wa,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_wa,
  input  logic [ADDR_W-1:0] qa,
  input  logic [ADDR_W-1:0] qb,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NREGS-1:0] bits_q;
  logic [NREGS-1:0] bits_d;

  // Clear first so a same-cycle set of the same register wins; x0 is never busy.
  always_comb begin
    bits_d = bits_q;
    if (clr_en) bits_d[clr_wa] = 1'b0;
    if (set_en) bits_d[set_wa] = 1'b1;
    bits_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bits_q <= '0;
    else        bits_q <= bits_d;
  end

  assign busy_a = bits_q[qa];
  assign busy_b = bits_q[qb];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port controller for the 2R1W register file: reset clear sweep, then
// pipeline/long-latency-unit arbitration with an LU busy scoreboard.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NREGS        = 2 ** ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int WAIT_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_wa,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_wa,
  input  logic [DATA_W-1:0] lu_wd,
  output logic              lu_ready,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_wa,
  input  logic [ADDR_W-1:0] sb_qa,
  input  logic [ADDR_W-1:0] sb_qb,
  output logic              sb_busy_a,
  output logic              sb_busy_b,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output rf_state_e         dbg_state
);

  // LU handshake: a result transfers in the cycle where lu_valid && lu_ready;
  // while lu_valid && !lu_ready the LU holds lu_wa/lu_wd stable. lu_ready is
  // combinational and never depends on lu_valid.

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              run;
  logic              pipe_hit;
  logic              lu_hs;
  logic              sb_a_raw;
  logic              sb_b_raw;

  assign run       = (state == ST_RUN);
  assign init_done = run;
  assign dbg_state = state;
  assign pipe_hit  = pipe_we && (pipe_wa != ADDR_W'(REG_X0));
  assign lu_hs     = lu_valid && lu_ready;

  always_comb begin
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wd    = '0;
    lu_ready = 1'b0;
    if (!run) begin
      rf_we = 1'b1;
      rf_wa = clr_cnt;
    end else if (pipe_hit) begin
      rf_we = 1'b1;
      rf_wa = pipe_wa;
      rf_wd = pipe_wd;
    end else begin
      lu_ready = 1'b1;
      // An LU result aimed at x0 still completes its handshake but writes nothing.
      if (lu_valid && (lu_wa != ADDR_W'(REG_X0))) begin
        rf_we = 1'b1;
        rf_wa = lu_wa;
        rf_wd = lu_wd;
      end
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (run && lu_valid && !lu_ready)
      wait_nxt = (wait_cnt >= WAIT_W'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= ADDR_W'(1);
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(NREGS - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          wait_cnt <= wait_nxt;
          if (lu_hs)                                   stall_req <= 1'b0;
          else if (wait_nxt == WAIT_W'(STARVE_LIMIT)) stall_req <= 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (run && sb_set),
    .set_wa (sb_set_wa),
    .clr_en (lu_hs),
    .clr_wa (lu_wa),
    .qa     (sb_qa),
    .qb     (sb_qb),
    .busy_a (sb_a_raw),
    .busy_b (sb_b_raw)
  );

  assign sb_busy_a = run && sb_a_raw;
  assign sb_busy_b = run && sb_b_raw;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wa = '0;
  logic [31:0] pipe_wd = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_wa = '0;
  logic [31:0] lu_wd = '0;
  logic        lu_ready;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_set_wa = '0;
  logic [4:0]  sb_qa = '0;
  logic [4:0]  sb_qb = '0;
  logic        sb_busy_a, sb_busy_b, stall_req, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  rf_state_e   dbg_state;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .sb_set(sb_set), .sb_set_wa(sb_set_wa), .sb_qa(sb_qa), .sb_qb(sb_qb),
    .sb_busy_a(sb_busy_a), .sb_busy_b(sb_busy_b), .stall_req(stall_req),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit        m_run;
  int        m_clr;
  bit        m_busy[32];
  int        m_waits;
  bit        m_stall;
  bit        last_hs;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_clr = 1; m_waits = 0; m_stall = 0; last_hs = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    exp_q.delete();
  endtask

  // One cycle: inputs already driven at the negedge; sample, then advance the model at posedge.
  task automatic step();
    bit          hit, exp_rdy, exp_we, hs;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [36:0] wr;
    #2;
    exp_wa = '0; exp_wd = '0;
    if (!m_run) begin
      exp_we = 1; exp_wa = 5'(m_clr); exp_wd = '0; exp_rdy = 0;
    end else begin
      hit = pipe_we && pipe_wa != 0;
      exp_rdy = !hit;
      if (hit) begin
        exp_we = 1; exp_wa = pipe_wa; exp_wd = pipe_wd;
      end else begin
        exp_we = lu_valid && lu_wa != 0; exp_wa = lu_wa; exp_wd = lu_wd;
      end
    end
    check("init_done", init_done, m_run);
    check("dbg_state", 64'(dbg_state), m_run);
    check("lu_ready", lu_ready, exp_rdy);
    check("rf_we", rf_we, exp_we);
    if (exp_we) exp_q.push_back({exp_wa, exp_wd});
    if (exp_we && rf_we) begin
      wr = exp_q.pop_front();
      check("rf_wa", rf_wa, wr[36:32]);
      check("rf_wd", rf_wd, wr[31:0]);
    end
    check("sb_busy_a", sb_busy_a, m_run && m_busy[sb_qa]);
    check("sb_busy_b", sb_busy_b, m_run && m_busy[sb_qb]);
    check("stall_req", stall_req, m_stall);
    @(posedge clk);
    hs = m_run && lu_valid && exp_rdy;
    if (!m_run) begin
      if (m_clr == 31) m_run = 1;
      m_clr++;
    end else begin
      if (hs && lu_wa != 0) m_busy[lu_wa] = 0;
      if (sb_set && sb_set_wa != 0) m_busy[sb_set_wa] = 1;
      if (hs) begin
        m_waits = 0; m_stall = 0;
      end else if (lu_valid) begin
        m_waits++;
        if (m_waits >= 4) m_stall = 1;
      end else begin
        m_waits = 0;
      end
    end
    last_hs = hs;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipe_we = 0; lu_valid = 0; sb_set = 0;
  endtask

  // Assert reset away from the edge, check reset-state outputs, release on a negedge.
  task automatic do_reset(input string tag);
    #1;
    rst_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_rf_we"}, rf_we, 1);
    check({tag, "_rf_wa"}, rf_wa, 1);
    check({tag, "_rf_wd"}, rf_wd, 0);
    check({tag, "_lu_ready"}, lu_ready, 0);
    check({tag, "_stall"}, stall_req, 0);
    check({tag, "_busy_a"}, sb_busy_a, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_sweep();
    for (int i = 0; i < 31; i++) step();
  endtask

  task automatic set_lu(input logic [4:0] wa, input logic [31:0] wd);
    lu_valid = 1; lu_wa = wa; lu_wd = wd;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    pipe_we = we; pipe_wa = wa; pipe_wd = wd;
  endtask

  initial begin : main
    int pct;
    model_reset();
    @(negedge clk);
    do_reset("por");

    // reset during the sweep, at clr_cnt = 12
    for (int i = 0; i < 11; i++) step();
    check("sweep_wa12", rf_wa, 12);
    do_reset("rst_sweep");
    run_sweep();
    check("run_after_sweep", init_done, 1);

    // pipeline beats LU, then LU drains
    set_pipe(1, 5, 32'hA5); set_lu(7, 32'h77);
    step();
    set_pipe(0, 0, 0);
    step();
    idle_inputs();
    step();

    // starvation: LU waits behind pipeline writes
    set_lu(12, 32'hC0FFEE); set_pipe(1, 4, 32'h44);
    for (int i = 0; i < 3; i++) step();
    check("stall_before4", stall_req, 0);
    step();
    check("stall_after4", stall_req, 1);
    step(); step();
    set_pipe(0, 0, 0);
    step();
    check("stall_cleared", stall_req, 0);
    idle_inputs();
    step();

    // scoreboard set / clear / same-cycle set+clear
    sb_qa = 9; sb_qb = 0; sb_set = 1; sb_set_wa = 9;
    step();
    sb_set = 0;
    check("sb_set9", sb_busy_a, 1);
    set_lu(9, 32'h99);
    step();
    lu_valid = 0;
    check("sb_clr9", sb_busy_a, 0);
    sb_set = 1;
    step();
    set_lu(9, 32'h999);
    step();
    idle_inputs();
    check("sb_setwins9", sb_busy_a, 1);
    step();

    // x0 corner cases
    set_pipe(1, 0, 32'hDEAD); set_lu(3, 32'h33);
    step();
    set_pipe(0, 0, 0); set_lu(0, 32'h1);
    step();
    idle_inputs();
    step();

    // reset while the LU is waiting
    set_lu(20, 32'h2020); set_pipe(1, 6, 32'h66);
    for (int i = 0; i < 5; i++) step();
    do_reset("rst_luwait");
    run_sweep();

    // random traffic with a varying pipeline load
    for (int n = 0; n < 1800; n++) begin
      if (n % 150 == 0) pct = (n / 150) % 3 == 0 ? 25 : ((n / 150) % 3 == 1 ? 70 : 97);
      if (!(lu_valid && !last_hs)) begin
        lu_valid = $urandom_range(0, 2) != 0;
        lu_wa = 5'($urandom_range(0, 31));
        lu_wd = $urandom;
      end
      pipe_we = $urandom_range(0, 99) < pct;
      pipe_wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_wd = $urandom;
      sb_set = $urandom_range(0, 2) == 0;
      sb_set_wa = 5'($urandom_range(0, 31));
      sb_qa = $urandom_range(0, 1) ? lu_wa : 5'($urandom_range(0, 31));
      sb_qb = 5'($urandom_range(0, 31));
      if (n == 900) begin
        do_reset("rst_rand");
        run_sweep();
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
